// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: request/result bundle for the nibble adder.
// master: start/a/b/sub out, busy/done/sum/cout/ovf/zero in; slave mirrors.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/sub run one nibble per cycle
// through a single 4-bit CLA slice; GG is chained back as next Cin.
// Ports: clk, rst_n (async, active low), bus (nibble_serial_adder_if.slave:
//   start/a/b/sub in; busy/done/sum/cout/ovf/zero out).
// Optional feature: define NSA_SUB_EN to honour bus.sub (A-B).

module nsa_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       gg_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_i);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);

  // Group generate folds in Cin, so it is the nibble carry-out.
  assign gg_o = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (&p & c_i);

  assign s_o = p ^ c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] opb_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic             cout_q;
  logic             cout_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             zero_q;
  logic             zero_d;

  logic [IW+1:0]    base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             gg;
  logic             msb_cin;
  logic [WIDTH-1:0] b_eff;
  logic             c_init;

`ifdef NSA_SUB_EN
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign c_init = bus.sub;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_eff  = bus.b;
  assign c_init = 1'b0;
`endif

  assign base  = {idx_q, 2'b00};
  assign nib_a = opa_q[base +: 4];
  assign nib_b = opb_q[base +: 4];

  nsa_cla4 u_cla (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .c_i  (carry_q),
    .s_o  (nib_s),
    .gg_o (gg)
  );

  // Carry into the MSB recovered from the top sum bit.
  assign msb_cin = opa_q[WIDTH-1]
                 ^ opb_q[WIDTH-1]
                 ^ nib_s[3];

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          opa_d   = bus.a;
          opb_d   = b_eff;
          carry_d = c_init;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d[base +: 4] = nib_s;
        carry_d = gg;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = gg;
          ovf_d   = msb_cin ^ gg;
          zero_d  = (acc_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: random and directed checks of the nibble adder
// against an integer-arithmetic model, WIDTH=16 and WIDTH=4 instances.
`timescale 1ns/1ps
module tb_nibble_serial_adder;
  localparam int N = 4;
`ifdef NSA_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] last_sum = '0;

  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, output logic [31:0] r, output logic c,
                       output logic v, output logic z);
    longint full, lim, ua, ub, sa, sb, res, rs;
    full = longint'(1) << w;
    lim  = full >> 1;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    sa = (ua >= lim) ? ua - full : ua;
    sb = (ub >= lim) ? ub - full : ub;
    if (SUB_ON && s) begin
      res = ua - ub;
      c   = (ua >= ub);
      rs  = sa - sb;
    end else begin
      res = ua + ub;
      c   = (res >= full);
      rs  = sa + sb;
    end
    v = (rs >= lim) || (rs < -lim);
    r = 32'(res & (full - 1));
    z = (r == 0);
  endtask

  task automatic wait_idle16();
    int i;
    @(posedge clk); #1;
    for (i = 0; i < 12; i++) begin
      if (!bus16.busy && !bus16.done) break;
      @(posedge clk); #1;
    end
    checks++;
    if (i == 12) begin
      errors++;
      $display("FAIL idle_wait: busy=%b done=%b never idle", bus16.busy, bus16.done);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input string name);
    logic [31:0] er;
    logic ec, ev, ez, stable;
    int lat;
    model(16, {16'h0, a}, {16'h0, b}, s, er, ec, ev, ez);
    wait_idle16();
    bus16.start = 1'b1;
    bus16.a = a;
    bus16.b = b;
    bus16.sub = s;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    checks++;
    if (bus16.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b want 1", name, bus16.busy);
    end
    lat = 0;
    stable = 1'b1;
    for (int cyc = 1; cyc <= N + 3; cyc++) begin
      bus16.a = 16'($urandom);
      bus16.b = 16'($urandom);
      bus16.sub = 1'($urandom);
      @(posedge clk); #1;
      if (bus16.done) begin
        lat = cyc;
        break;
      end
      if (bus16.sum !== last_sum) stable = 1'b0;
    end
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, N);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_stable: sum moved before done, want %h", name, last_sum);
    end
    checks++;
    if (bus16.sum !== er[15:0]) begin
      errors++;
      $display("FAIL %s_sum: got %h want %h", name, bus16.sum, er[15:0]);
    end
    checks++;
    if ({bus16.cout, bus16.ovf, bus16.zero} !== {ec, ev, ez}) begin
      errors++;
      $display("FAIL %s_flags: got c%b v%b z%b want c%b v%b z%b", name,
               bus16.cout, bus16.ovf, bus16.zero, ec, ev, ez);
    end
    last_sum = er[15:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0;
    bus4.start = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.sub = 1'b0;
    #12;
    checks++;
    if ({bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: b%b d%b s%h c%b v%b z%b want all 0", bus16.busy,
               bus16.done, bus16.sum, bus16.cout, bus16.ovf, bus16.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run16(16'h0001, 16'h0001, 1'b0, "pre_reset");
    wait_idle16();
    bus16.start = 1'b1;
    bus16.a = 16'h1234;
    bus16.b = 16'h1111;
    bus16.sub = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus16.busy, bus16.done, bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: b%b d%b s%h c%b v%b z%b want all 0", bus16.busy,
               bus16.done, bus16.sum, bus16.cout, bus16.ovf, bus16.zero);
    end
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < N + 3; i++) begin
        @(posedge clk); #1;
        if (bus16.done || bus16.busy || bus16.sum !== 16'h0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL reset_no_done: activity after abort, want none");
      end
    end
  endtask

  task automatic test_ripple();
    run16(16'hFFFF, 16'h0001, 1'b0, "ripple");
    checks++;
    if ({bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== {16'h0000, 3'b101}) begin
      errors++;
      $display("FAIL ripple_const: got %h c%b v%b z%b want 0000 c1 v0 z1",
               bus16.sum, bus16.cout, bus16.ovf, bus16.zero);
    end
  endtask

  task automatic test_overflow();
    run16(16'h7FFF, 16'h0001, 1'b0, "ovf");
    checks++;
    if ({bus16.sum, bus16.cout, bus16.ovf, bus16.zero} !== {16'h8000, 3'b010}) begin
      errors++;
      $display("FAIL ovf_const: got %h c%b v%b z%b want 8000 c0 v1 z0",
               bus16.sum, bus16.cout, bus16.ovf, bus16.zero);
    end
  endtask

  task automatic test_sub();
    logic [15:0] want;
    run16(16'h0005, 16'h0007, 1'b1, "sub");
    want = SUB_ON ? 16'hFFFE : 16'h000C;
    checks++;
    if (bus16.sum !== want || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_const: got %h c%b v%b want %h c0 v0",
               bus16.sum, bus16.cout, bus16.ovf, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_ignore();
    int cyc;
    wait_idle16();
    bus16.start = 1'b1;
    bus16.a = 16'h1000;
    bus16.b = 16'h0234;
    bus16.sub = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    for (cyc = 1; cyc <= N + 3; cyc++) begin
      bus16.start = (cyc == 2);
      bus16.a = 16'hFFFF;
      bus16.b = 16'hFFFF;
      @(posedge clk); #1;
      if (bus16.done) break;
    end
    checks++;
    if (cyc != N) begin
      errors++;
      $display("FAIL ignore_latency: got %0d want %0d", cyc, N);
    end
    bus16.start = 1'b1;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    checks++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_edge: busy=%b done=%b want 0 0", bus16.busy, bus16.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus16.busy !== 1'b0 || bus16.sum !== 16'h1234) begin
      errors++;
      $display("FAIL ignore_after: busy=%b sum=%h want 0 1234", bus16.busy, bus16.sum);
    end
    last_sum = 16'h1234;
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa, ob;
    logic os, ec, ev, ez, wd;
    logic [31:0] er;
    wait_idle16();
    bus16.start = 1'b1;
    oa = '0; ob = '0; os = 1'b0;
    for (int t = 0; t < 3 * (N + 2); t++) begin
      bus16.a = 16'($urandom);
      bus16.b = 16'($urandom);
      bus16.sub = 1'($urandom);
      if (t % (N + 2) == 0) begin
        oa = bus16.a; ob = bus16.b; os = bus16.sub;
      end
      @(posedge clk); #1;
      wd = (t % (N + 2) == N);
      checks++;
      if (bus16.done !== wd) begin
        errors++;
        $display("FAIL b2b_done t=%0d: got %b want %b", t, bus16.done, wd);
      end
      if (wd) begin
        model(16, {16'h0, oa}, {16'h0, ob}, os, er, ec, ev, ez);
        last_sum = er[15:0];
        checks++;
        if ({bus16.cout, bus16.ovf, bus16.zero} !== {ec, ev, ez}) begin
          errors++;
          $display("FAIL b2b_flags t=%0d: got c%b v%b z%b want c%b v%b z%b", t,
                   bus16.cout, bus16.ovf, bus16.zero, ec, ev, ez);
        end
      end
      checks++;
      if (bus16.sum !== last_sum) begin
        errors++;
        $display("FAIL b2b_sum t=%0d: got %h want %h", t, bus16.sum, last_sum);
      end
    end
    bus16.start = 1'b0;
  endtask

  task automatic test_w4();
    logic [31:0] er;
    logic ec, ev, ez;
    logic [3:0] a, b;
    logic s;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 4'h9 : 4'($urandom);
      b = (i == 0) ? 4'h8 : 4'($urandom);
      s = (i == 0) ? 1'b0 : 1'($urandom);
      model(4, {28'h0, a}, {28'h0, b}, s, er, ec, ev, ez);
      @(posedge clk); #1;
      for (int k = 0; k < 4 && (bus4.busy || bus4.done); k++) begin
        @(posedge clk); #1;
      end
      bus4.start = 1'b1;
      bus4.a = a;
      bus4.b = b;
      bus4.sub = s;
      @(posedge clk); #1;
      bus4.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        if (bus4.done) begin
          lat = c;
          break;
        end
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL w4_latency: got %0d want 1", lat);
      end
      checks++;
      if ({bus4.sum, bus4.cout, bus4.ovf, bus4.zero} !== {er[3:0], ec, ev, ez}) begin
        errors++;
        $display("FAIL w4_result %h op %h: got %h c%b v%b z%b want %h c%b v%b z%b",
                 a, b, bus4.sum, bus4.cout, bus4.ovf, bus4.zero, er[3:0], ec, ev, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_overflow();
    test_sub();
    test_random();
    test_ignore();
    test_back_to_back();
    test_w4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that sequences operands one nibble per cycle through an internal 4-bit carry-lookahead slice and chains the slice's group-generate output back as the next nibble's carry-in. It sits between the decode/operand registers and the 4-bit CLA slice. It feeds that slice A/B/Cin nibbles, consumes its S and GG outputs, and returns a full-width result with flags to the ALU result mux. It exists for area-constrained builds where one 4-bit slice replaces a full-width adder tree.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibbles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- sub  in  1  1 = A−B; captured with operands; ignored (treated 0) without NSA_SUB_EN.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held stable from done until the next done.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All outputs are 0 at reset, as are the internal operand, accumulator, carry and index registers.
- IDLE → RUN on start=1:
  - Capture a into opA.
  - Capture b into opB, or ~b when sub=1 (macro enabled).
  - Set carry = sub and idx = 0.
- Each RUN cycle:
  - Slice inputs: A = opA[4·idx+3:4·idx], B = opB nibble, Cin = carry.
  - acc nibble idx ← S; carry ← GG; idx ← idx+1.
  - GG includes the Cin term, so it equals the nibble carry-out.
- RUN → DONE on the edge that processes idx = N−1. On that same edge:
  - sum ← completed acc.
  - cout ← GG.
  - ovf ← carry into bit WIDTH−1 XOR GG. Carry-in to the MSB = opA[MSB] ^ opB[MSB] ^ S[3].
  - zero ← (completed acc == 0).
- DONE → IDLE unconditionally after one cycle. done = (state == DONE).
- start is ignored in RUN and DONE; no queuing. A request is dropped unless start is held into IDLE.
- a, b and sub may change freely after the accepted edge; captured copies are used.
- sum and the flags change only on the RUN→DONE edge. Partial results are never visible.
- Reset mid-RUN aborts the operation. Outputs clear to 0 immediately (asynchronous) and there is no done pulse.
- Arithmetic is modulo 2^WIDTH. WIDTH=4 degenerates to a single RUN cycle.

## Timing
- Accepting edge E0: busy=1 after E0.
- Nibble i is written at edge E(i+1), so the last nibble is written at EN.
- After EN: busy=0, done=1, and sum/flags are valid.
- After E(N+1): done=0, state is IDLE.
- Latency from accepting edge to done = N cycles (4 for WIDTH=16). Throughput is one operation per N+2 cycles at best: start must be high in IDLE.
- Back-to-back: start held high continuously is accepted at E(N+1)+1 cycle, i.e. the first IDLE cycle edge.
- Combinational path per cycle: one 4-bit CLA slice plus the carry register. There is no combinational path from inputs to outputs.

## Configuration
- NSA_SUB_EN defined: sub is honoured. opB = ~b and the initial carry = 1 when sub=1. cout = 1 means no borrow; ovf is the signed subtract overflow.
- NSA_SUB_EN undefined: sub is ignored. The inversion mux is not built and the initial carry is always 0. Add-only behaviour is identical to sub=0 with the macro defined.

## Test plan
- Reset: assert rst_n=0 mid-RUN (a=16'h1234, b=16'h1111) → busy/done/sum/cout/ovf/zero go 0 immediately; no done pulse after release.
- Carry ripple across all nibbles: a=16'hFFFF, b=16'h0001 → done exactly 4 cycles after the accepting edge; sum=16'h0000, cout=1, zero=1, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001 → sum=16'h8000, cout=0, ovf=1, zero=0.
- Subtract (NSA_SUB_EN): a=16'h0005, b=16'h0007, sub=1 → sum=16'hFFFE, cout=0 (borrow), ovf=0. Same stimulus without the macro → sum=16'h000C.
- Handshake: pulse start again during RUN and during DONE → ignored. start held high → second operation accepted on the first IDLE edge, and done pulses are spaced N+2 cycles apart. sum is stable between done pulses even though a and b change every cycle.
- WIDTH=4 instance: a=4'h9, b=4'h8 → done 1 cycle after accept, sum=4'h1, cout=1, ovf=1.
